// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity path.
// State encoding of the serializer FSM and the frame-parity polarity constants
// (PAR_EVEN / PAR_ODD), which checker benches reuse as well.
package parity_pkg;

  // 2-bit state encoding: IDLE -> SHIFT -> PARITY -> GAP -> IDLE
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_shiftreg.sv
// WIDTH-bit load / shift-right register with a running-XOR accumulator.
// Ports:
//   clock, reset  : clock, async active-high reset
//   load          : capture data_in, clear accumulator
//   shift         : shift right by one, fold the outgoing bit into par_acc
//   data_in       : parallel word
//   lsb           : bit currently at the serial end (sreg[0])
//   par_acc       : XOR of every bit shifted out since the last load
module parity_shiftreg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             lsb,
  output logic             par_acc
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg    <= '0;
      par_acc <= 1'b0;
    end else if (load) begin
      sreg    <= data_in;
      par_acc <= 1'b0;
    end else if (shift) begin
      sreg    <= sreg >> 1;
      par_acc <= par_acc ^ sreg[0];
    end
  end

  assign lsb = sreg[0];

endmodule

// File: rtl/parity_serializer.sv
// Parallel-to-serial framer feeding the serial parity checker.
// Accepts a word on valid_in & ready_out, shifts it out LSB-first on x (one bit
// per clock), appends one parity bit, then holds x = 0 for GAP_CYCLES cycles.
// Ports:
//   clock, reset : clock, async active-high reset
//   data_in      : word to send (sampled on accept only)
//   valid_in     : producer has a word
//   ready_out    : serializer idle and able to accept
//   x            : serial stream
//   frame        : x carries a data or parity bit
//   par_bit      : x carries the parity bit
//   busy         : FSM not idle
// All outputs decode from registered state only, never from valid_in/data_in.
module parity_serializer
  import parity_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic ODD_PARITY = PAR_EVEN,
  parameter int   GAP_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             x,
  output logic             frame,
  output logic             par_bit,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  BIT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  BIT_SAT  = CW'(WIDTH);
  // GAP is only entered when GAP_CYCLES > 0, so the 0 case never uses this
  localparam logic [3:0]     GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    gap_cnt;
  logic          accept;
  logic          sr_lsb;
  logic          sr_par;

  assign accept = valid_in & ready_out;

  parity_shiftreg #(.WIDTH(WIDTH)) u_sreg (
    .clock   (clock),
    .reset   (reset),
    .load    (accept),
    .shift   (state == S_SHIFT),
    .data_in (data_in),
    .lsb     (sr_lsb),
    .par_acc (sr_par)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            bit_cnt <= '0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // saturates at WIDTH on the exit edge
          if (bit_cnt != BIT_SAT) bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) state <= S_PARITY;
        end
        S_PARITY: begin
          gap_cnt <= '0;
          state   <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
        S_GAP: begin
          if (gap_cnt != 4'hF) gap_cnt <= gap_cnt + 4'd1;
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode: reset forces state to IDLE, so x/frame drop immediately.
  assign ready_out = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign frame     = (state == S_SHIFT) || (state == S_PARITY);
  assign par_bit   = (state == S_PARITY);
  assign x         = (state == S_SHIFT)  ? sr_lsb :
                     (state == S_PARITY) ? (sr_par ^ ODD_PARITY) : 1'b0;

endmodule
